// File: rtl/surf_event_pkg.sv
// surf_event_pkg: shared state type and header constants for the SURF event merger.
package surf_event_pkg;
    localparam int SURF_BYTES_DEFAULT = 12292;
    localparam int HDR_LEN = 4;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    typedef enum logic [1:0] {IDLE, HEADER, SURF} state_t;
endpackage

// File: rtl/surf_event_merger_if.sv
// surf_event_merger_if: per-SURF input streams plus the merged output stream.
interface surf_event_merger_if #(
    parameter int NSURF = 7
);
    logic [8*NSURF-1:0] s_dout_tdata;
    logic [NSURF-1:0]   s_dout_tvalid;
    logic [NSURF-1:0]   s_dout_tready;
    logic [NSURF-1:0]   s_dout_tlast;
    logic [7:0]         m_ev_tdata;
    logic               m_ev_tvalid;
    logic               m_ev_tready;
    logic               m_ev_tlast;
    modport master (
        output s_dout_tdata, s_dout_tvalid, s_dout_tlast, m_ev_tready,
        input  s_dout_tready, m_ev_tdata, m_ev_tvalid, m_ev_tlast
    );
    modport slave (
        input  s_dout_tdata, s_dout_tvalid, s_dout_tlast, m_ev_tready,
        output s_dout_tready, m_ev_tdata, m_ev_tvalid, m_ev_tlast
    );
endinterface

// File: rtl/event_out_reg.sv
// event_out_reg: single-stage AXI4-stream register slice for 8-bit data plus last.
module event_out_reg (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_last,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_load_ok
);
    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last;

    assign o_load_ok = !r_valid || i_ready;
    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_last    = r_last;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (o_load_ok) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_last <= i_last;
            end
        end
    end
endmodule

// File: rtl/surf_event_merger.sv
// surf_event_merger: serialises one event per SURF, in order 0..NSURF-1, onto one byte stream.
// Define SURF_EVENT_MERGER_HEADER_EN to prepend a 4-byte header to each merged event.
module surf_event_merger
    import surf_event_pkg::*;
#(
    parameter int NSURF      = 7,
    parameter int SURF_BYTES = SURF_BYTES_DEFAULT
) (
    input  logic               aclk,
    input  logic               aresetn,
    surf_event_merger_if.slave bus,
    output logic [NSURF-1:0]   err_o,
    output logic [15:0]        event_count_o
);
    localparam int SW = NSURF > 1 ? $clog2(NSURF) : 1;
    localparam int CW = $clog2(SURF_BYTES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SURF_BYTES - 1);
    localparam logic [SW-1:0] LAST_SEL = SW'(NSURF - 1);

    state_t           r_state, w_next;
    logic [SW-1:0]    r_sel;
    logic [CW-1:0]    r_byte_cnt;
    logic [NSURF-1:0] r_err;
    logic [15:0]      r_ev_cnt;
    logic             w_load_ok, w_accept, w_seg_end, w_out_valid, w_out_last;
    logic [7:0]       w_out_data;
    logic             w_hdr_valid, w_hdr_last;
    logic [7:0]       w_hdr_byte;

`ifdef SURF_EVENT_MERGER_HEADER_EN
    localparam state_t FIRST = HEADER;
    logic [1:0] r_hdr_cnt;

    always_comb begin
        w_hdr_valid = r_state == HEADER;
        w_hdr_last  = r_hdr_cnt == 2'(HDR_LEN - 1);
        w_hdr_byte  = r_hdr_cnt == 2'd0 ? r_ev_cnt[15:8] :
                      r_hdr_cnt == 2'd1 ? r_ev_cnt[7:0] :
                      r_hdr_cnt == 2'd2 ? 8'(NSURF) : HDR_MAGIC;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || r_state != HEADER)
            r_hdr_cnt <= '0;
        else if (w_load_ok)
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
    end
`else
    localparam state_t FIRST = SURF;

    always_comb begin
        w_hdr_valid = 1'b0;
        w_hdr_last  = 1'b0;
        w_hdr_byte  = '0;
    end
`endif

    always_comb begin
        w_accept    = r_state == SURF && bus.s_dout_tvalid[r_sel] && w_load_ok;
        // the byte count is authoritative: a segment ends at full length even without tlast
        w_seg_end   = w_accept && (bus.s_dout_tlast[r_sel] || r_byte_cnt == LAST_CNT);
        w_out_valid = w_accept || w_hdr_valid;
        w_out_data  = w_accept ? bus.s_dout_tdata[{r_sel, 3'b000} +: 8] : w_hdr_byte;
        w_out_last  = w_seg_end && r_sel == LAST_SEL;
        bus.s_dout_tready        = '0;
        bus.s_dout_tready[r_sel] = r_state == SURF && w_load_ok;
    end

    always_ff @(posedge aclk) begin
        r_state <= !aresetn ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.s_dout_tvalid[0]) w_next = FIRST;
            HEADER:  if (w_load_ok && w_hdr_last) w_next = SURF;
            SURF:    if (w_seg_end && r_sel == LAST_SEL) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn || r_state == IDLE) begin
            r_sel      <= '0;
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_byte_cnt <= w_seg_end ? '0 : r_byte_cnt + CW'(1);
            if (w_seg_end)
                r_sel <= r_sel == LAST_SEL ? '0 : r_sel + SW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_err    <= '0;
            r_ev_cnt <= '0;
        end else if (w_seg_end) begin
            if (bus.s_dout_tlast[r_sel] != (r_byte_cnt == LAST_CNT))
                r_err[r_sel] <= 1'b1;
            if (r_sel == LAST_SEL)
                r_ev_cnt <= r_ev_cnt + 16'd1;
        end
    end

    assign err_o         = r_err;
    assign event_count_o = r_ev_cnt;

    event_out_reg u_out (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_valid   (w_out_valid),
        .i_data    (w_out_data),
        .i_last    (w_out_last),
        .i_ready   (bus.m_ev_tready),
        .o_valid   (bus.m_ev_tvalid),
        .o_data    (bus.m_ev_tdata),
        .o_last    (bus.m_ev_tlast),
        .o_load_ok (w_load_ok)
    );
endmodule

// File: tb/tb_surf_event_merger.sv
// tb_surf_event_merger: random traffic against a segment-level reference model of the merger.
module tb_surf_event_merger;
    localparam int NS = 2;
    localparam int SB = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [NS-1:0] err_o;
    logic [15:0]   event_count_o;
    int            n_checks = 0;
    int            n_fails = 0;
    int            bubble_pct = 0;
    int            stall_pct = 0;
    int            exp_events = 0;
    logic [NS-1:0] exp_err = '0;
    logic [8:0]    src_q[NS][$];
    logic [8:0]    exp_q[$];
    logic          held_valid = 1'b0;
    logic [8:0]    held_beat = '0;

    surf_event_merger_if #(.NSURF(NS)) bus ();

    surf_event_merger #(.NSURF(NS), .SURF_BYTES(SB)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .bus           (bus),
        .err_o         (err_o),
        .event_count_o (event_count_o)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_header();
`ifdef SURF_EVENT_MERGER_HEADER_EN
        logic [15:0] n = 16'(exp_events);
        exp_q.push_back({1'b0, n[15:8]});
        exp_q.push_back({1'b0, n[7:0]});
        exp_q.push_back({1'b0, 8'(NS)});
        exp_q.push_back(9'h0A5);
`endif
    endtask

    // a segment is whatever the source sends up to its tlast or SB bytes, whichever comes first
    task automatic add_segment(input int s, input int len, input bit has_last);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b = 8'($urandom);
            src_q[s].push_back({has_last && k == len - 1, b});
            exp_q.push_back({s == NS - 1 && k == len - 1, b});
        end
        if (len != SB || !has_last) exp_err[s] = 1'b1;
    endtask

    task automatic add_event(input int bad_s, input int bad_len, input bit bad_last);
        add_header();
        for (int s = 0; s < NS; s++)
            if (s == bad_s) add_segment(s, bad_len, bad_last);
            else add_segment(s, SB, 1'b1);
        exp_events++;
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(negedge aclk);
            c++;
        end
        check("drain", exp_q.size(), 0);
        repeat (4) @(negedge aclk);
        check("src_drained", src_q[0].size() + src_q[1].size(), 0);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, event_count_o, 16'(exp_events));
        check({tag, "_err"}, err_o, exp_err);
    endtask

    initial begin
        logic [8:0] b;
        bus.m_ev_tready   = 1'b0;
        bus.s_dout_tvalid = '0;
        bus.s_dout_tdata  = '0;
        bus.s_dout_tlast  = '0;
        forever begin
            @(negedge aclk);
            bus.m_ev_tready = $urandom_range(99) >= stall_pct;
            for (int s = 0; s < NS; s++) begin
                b = src_q[s].size() != 0 ? src_q[s][0] : 9'h0;
                bus.s_dout_tvalid[s]       = src_q[s].size() != 0 && $urandom_range(99) >= bubble_pct;
                bus.s_dout_tdata[8*s +: 8] = b[7:0];
                bus.s_dout_tlast[s]        = b[8];
            end
            #1;
            if (aresetn) begin
                if (held_valid) begin
                    check("hold_valid", 32'(bus.m_ev_tvalid), 1);
                    check("hold_beat", {bus.m_ev_tlast, bus.m_ev_tdata}, held_beat);
                end
                held_valid = bus.m_ev_tvalid && !bus.m_ev_tready;
                held_beat  = {bus.m_ev_tlast, bus.m_ev_tdata};
                check("tready_onehot", 32'($countones(bus.s_dout_tready) <= 1), 1);
                for (int s = 0; s < NS; s++)
                    if (bus.s_dout_tvalid[s] && bus.s_dout_tready[s]) void'(src_q[s].pop_front());
                if (bus.m_ev_tvalid && bus.m_ev_tready) begin
                    check("beat_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        check("tdata", bus.m_ev_tdata, b[7:0]);
                        check("tlast", 32'(bus.m_ev_tlast), 32'(b[8]));
                    end
                end
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    initial begin
        int c;
        repeat (3) @(negedge aclk);
        #2;
        check("rst_tvalid", 32'(bus.m_ev_tvalid), 0);
        check("rst_tdata", bus.m_ev_tdata, 0);
        check("rst_tlast", 32'(bus.m_ev_tlast), 0);
        check("rst_tready", bus.s_dout_tready, 0);
        check_state("rst");
        aresetn = 1'b1;

        add_event(-1, 0, 1'b0);
        drain();
        check_state("basic");

        stall_pct = 50;
        add_event(-1, 0, 1'b0);
        add_event(-1, 0, 1'b0);
        drain();
        check_state("stall");

        stall_pct = 0;
        add_event(1, 5, 1'b1);
        drain();
        check_state("short_tlast");
        add_event(-1, 0, 1'b0);
        drain();
        check_state("after_short");

        add_event(0, SB, 1'b0);
        drain();
        check_state("no_tlast");

        add_event(-1, 0, 1'b0);
        c = 0;
        while (exp_q.size() > 5 && c < 500) begin
            @(negedge aclk);
            c++;
        end
        aresetn = 1'b0;
        #2;
        for (int s = 0; s < NS; s++) src_q[s].delete();
        exp_q.delete();
        exp_err    = '0;
        exp_events = 0;
        @(negedge aclk);
        #2;
        check("mid_rst_tvalid", 32'(bus.m_ev_tvalid), 0);
        check("mid_rst_tdata", bus.m_ev_tdata, 0);
        check("mid_rst_tlast", 32'(bus.m_ev_tlast), 0);
        check("mid_rst_tready", bus.s_dout_tready, 0);
        check_state("mid_rst");
        aresetn = 1'b1;
        add_event(-1, 0, 1'b0);
        drain();
        check_state("post_rst");

        bubble_pct = 25;
        stall_pct  = 25;
        for (int e = 0; e < 30; e++) begin
            int r = int'($urandom_range(3));
            int s = int'($urandom_range(NS - 1));
            if (r == 1) add_event(s, int'($urandom_range(SB - 1, 1)), 1'b1);
            else if (r == 2) add_event(s, SB, 1'b0);
            else add_event(-1, 0, 1'b0);
        end
        drain();
        check_state("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/surf_event_merger.md
# surf_event_merger

Downstream stage of the per-SURF masked splice FIFOs. It takes NSURF 8-bit event streams, each framed with tlast, and serialises one complete event from every SURF in fixed order 0..NSURF-1 into a single 8-bit event stream for the TURF link. Framing is checked per SURF against the fixed event length. Length errors are flagged but never stall the merge.

## Interface
- NSURF, 7: number of SURF input streams.
- SURF_BYTES, 12292: bytes per SURF event (8 ch × 1536 + 4 header).
- aclk in 1: the single clock.
- aresetn in 1: synchronous, active-low reset.
- s_dout_tdata in 8*NSURF: input data; SURF i is bits [8i+7:8i].
- s_dout_tvalid in NSURF: per-SURF valid.
- s_dout_tready out NSURF: per-SURF ready; only the selected SURF's bit can be 1.
- s_dout_tlast in NSURF: per-SURF end of event.
- m_ev_tdata out 8: merged data.
- m_ev_tvalid out 1: merged valid.
- m_ev_tready in 1: downstream ready.
- m_ev_tlast out 1: last byte of the merged event.
- err_o out NSURF: sticky per-SURF framing error.
- event_count_o out 16: number of completed merged events.

## Operation
- States: IDLE, HEADER, SURF.
- IDLE
  - sel = 0, byte_cnt = 0, hdr_cnt = 0.
  - When s_dout_tvalid[0]=1, go to HEADER if SURF_EVENT_MERGER_HEADER_EN is defined, otherwise go to SURF.
  - All s_dout_tready = 0.
- HEADER
  - Emits 4 bytes, one per output-register load (see Configuration).
  - After the 4th load, go to SURF.
  - All s_dout_tready = 0.
- SURF
  - s_dout_tready[sel] = load_ok. All other tready bits = 0.
  - A beat is accepted when s_dout_tvalid[sel] && s_dout_tready[sel]. Each accepted beat is copied into the output register and increments byte_cnt.
- A segment ends on an accepted beat where s_dout_tlast[sel]=1 OR byte_cnt == SURF_BYTES-1. The count is authoritative:
  - tlast with byte_cnt != SURF_BYTES-1: set err_o[sel]; the segment ends.
  - byte_cnt == SURF_BYTES-1 without tlast: set err_o[sel]; the segment ends.
- At segment end:
  - byte_cnt ← 0.
  - If sel == NSURF-1: the output byte carries m_ev_tlast=1, event_count_o increments (16-bit, wraps 0xFFFF→0), sel ← 0, go to IDLE.
  - Otherwise sel ← sel+1 and stay in SURF.
- Input tlast bits never propagate directly; m_ev_tlast is asserted only on the final byte of SURF NSURF-1.
- err_o bits clear only on reset.

## Timing
- Output is a single register stage: load_ok = !m_ev_tvalid || m_ev_tready.
- Latency is 1 cycle from input accept to m_ev_tvalid.
- Full throughput is 1 byte/clk while downstream is ready.
- Once asserted, m_ev_tvalid/tdata/tlast hold stable until m_ev_tready=1 (AXI4-stream rule).
- IDLE→HEADER/SURF costs 1 cycle. There are no bubbles between SURF segments or between header and SURF0.
- Reset (aresetn=0 sampled high edge): state=IDLE, m_ev_tvalid=0, m_ev_tdata=0, m_ev_tlast=0, s_dout_tready=0, err_o=0, event_count_o=0.
- Reset mid-event discards the partial event and emits no tlast. Upstream FIFOs are reset by the same aresetn.
- A selected SURF with tvalid=0 stalls the merge indefinitely. There is no timeout.

## Configuration
- SURF_EVENT_MERGER_HEADER_EN defined:
  - HEADER state is compiled in. Bytes, in order: event_count_o[15:8], event_count_o[7:0], NSURF[7:0], 8'hA5.
  - Merged event length = 4 + NSURF*SURF_BYTES.
- Not defined:
  - HEADER state and header mux are absent; IDLE goes straight to SURF.
  - Merged event length = NSURF*SURF_BYTES.

## Structure
- Package surf_event_pkg holds:
  - SURF_BYTES_DEFAULT (12292).
  - The state typedef (IDLE/HEADER/SURF).
  - HDR_MAGIC (8'hA5) and HDR_LEN (4).
- Sub-module event_out_reg: a one-stage 9-bit AXI4-stream register slice (data+last) that produces load_ok. It is instantiated once for the m_ev_ port.

## Test plan
- NSURF=2, SURF_BYTES=8, header enabled, all valid, m_ev_tready=1 → 20 bytes out: 00,00,02,A5, then SURF0's 8 bytes, then SURF1's 8 bytes. tlast only on byte 20. event_count_o=1. err_o=0.
- Same event with m_ev_tready toggling 1,0 each cycle → identical byte sequence; data stable while stalled; no loss or duplication.
- SURF1 asserts tlast on its 5th byte → err_o=2'b10. Output has 8+5 SURF bytes with tlast on the last one. The next event merges normally.
- SURF0 sends 8 bytes without tlast → err_o[0]=1; sel advances to SURF1 after byte 8.
- aresetn low mid-SURF1 → all outputs return to reset values the next cycle. The following event starts with header 00,00,02,A5.
- Header disabled, 0x10000 events → event_count_o wraps to 0 and the tlast count equals the number of events.
